// File: rtl/sram_nr1w.sv
// Simulation-model SRAM: one byte-enabled write port, N synchronous read ports,
// selectable read-during-write behaviour and an optional post-reset clear.
module sram_nr1w #(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 64,
    parameter int    ADDR_WIDTH        = $clog2(SIZE),
    parameter int    NUM_READ_PORTS    = 2,
    parameter string READ_DURING_WRITE = "NEW_DATA",
    parameter bit    CLEAR_ON_RESET    = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   write_en,
    input  logic [ADDR_WIDTH-1:0]                  write_adr,
    input  logic [DATA_WIDTH-1:0]                  write_data,
    input  logic [DATA_WIDTH/8-1:0]                write_byte_en,
    input  logic [NUM_READ_PORTS-1:0]              read_en,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]   read_adr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   read_data,
    output logic                                   ready
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [ADDR_WIDTH:0]   SIZE_X = (ADDR_WIDTH+1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

    localparam int MODE_NEW = 0;
    localparam int MODE_OLD = 1;
    localparam int MODE_DC  = 2;
    localparam int MODE =
        (READ_DURING_WRITE == "OLD_DATA")  ? MODE_OLD :
        (READ_DURING_WRITE == "DONT_CARE") ? MODE_DC  : MODE_NEW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  clr_go;
    logic                  wr_go;
    logic [IW-1:0]         wr_idx;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < SIZE_X;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    assign ready  = !reset && (state == ST_IDLE);
    assign clr_go = !reset && (state == ST_CLEAR);
    assign wr_go  = ready && write_en && in_range(write_adr);
    assign wr_idx = write_adr[IW-1:0];

    // Clear sequencer: walk every entry once after reset, then serve traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clear_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clear_cnt <= clear_cnt + 1'b1;
            if (clear_cnt == LAST)
                state <= ST_IDLE;
        end
    end

    // Storage update: clear writes zero, normal writes merge enabled bytes.
    always_ff @(posedge clk) begin
        if (clr_go)
            mem[clear_cnt[IW-1:0]] <= '0;
        else if (wr_go)
            mem[wr_idx] <= merge(mem[wr_idx], write_data, write_byte_en);
    end

    // Out-of-range write addresses are dropped; flag them in simulation.
    always_ff @(posedge clk) begin
        if (ready && write_en)
            assert (in_range(write_adr))
            else $warning("sram_nr1w: write address %0d out of range", write_adr);
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] adr;
        logic                  ok;
        logic                  hit;
        logic [DATA_WIDTH-1:0] old_w;
        logic [DATA_WIDTH-1:0] new_w;
        logic [DATA_WIDTH-1:0] rd_q;

        assign adr = read_adr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Current word and its post-write value for collision handling.
        always_comb begin
            ok    = in_range(adr);
            old_w = '0;
            if (ok) old_w = mem[adr[IW-1:0]];
            hit   = ok && write_en && (write_adr == adr);
            new_w = merge(old_w, write_data, write_byte_en);
        end

        // Read register: zero outside IDLE, hold when not strobed.
        always_ff @(posedge clk) begin
            if (reset || state != ST_IDLE)
                rd_q <= '0;
            else if (read_en[p]) begin
                if (!hit)
                    rd_q <= old_w;
                else if (MODE == MODE_OLD)
                    rd_q <= old_w;
                else if (MODE == MODE_DC)
                    rd_q <= ~new_w;
                else
                    rd_q <= new_w;
            end
        end

        // Out-of-range read addresses return zero; flag them in simulation.
        always_ff @(posedge clk) begin
            if (ready && read_en[p])
                assert (ok)
                else $warning("sram_nr1w: read port %0d address %0d out of range", p, adr);
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

endmodule

// File: tb/tb_sram_nr1w.sv
// Bench for sram_nr1w: three instances, one per read-during-write mode,
// driven in lockstep and checked against a reference model via a scoreboard.
module tb_sram_nr1w;

    typedef struct {
        string       tag;
        int          inst;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         write_en = 1'b0;
    logic [6:0]   write_adr = '0;
    logic [31:0]  write_data = '0;
    logic [3:0]   write_byte_en = '0;
    logic [3:0]   read_en = '0;
    logic [27:0]  read_adr = '0;
    logic [127:0] rd_n, rd_o, rd_d;
    logic         rdy_n, rdy_o, rdy_d;

    logic [31:0]  model [64];
    exp_t         sb [$];
    logic         pend_we = 1'b0;
    int           pend_wa = 0;
    logic [31:0]  pend_wd = '0;
    logic [3:0]   pend_be = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    sram_nr1w #(.DATA_WIDTH(32), .SIZE(64), .ADDR_WIDTH(7), .NUM_READ_PORTS(4),
                .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1'b1)) u_new (
        .clk(clk), .reset(reset), .write_en(write_en), .write_adr(write_adr),
        .write_data(write_data), .write_byte_en(write_byte_en), .read_en(read_en),
        .read_adr(read_adr), .read_data(rd_n), .ready(rdy_n));

    sram_nr1w #(.DATA_WIDTH(32), .SIZE(64), .ADDR_WIDTH(7), .NUM_READ_PORTS(4),
                .READ_DURING_WRITE("OLD_DATA"), .CLEAR_ON_RESET(1'b1)) u_old (
        .clk(clk), .reset(reset), .write_en(write_en), .write_adr(write_adr),
        .write_data(write_data), .write_byte_en(write_byte_en), .read_en(read_en),
        .read_adr(read_adr), .read_data(rd_o), .ready(rdy_o));

    sram_nr1w #(.DATA_WIDTH(32), .SIZE(64), .ADDR_WIDTH(7), .NUM_READ_PORTS(4),
                .READ_DURING_WRITE("DONT_CARE"), .CLEAR_ON_RESET(1'b1)) u_dc (
        .clk(clk), .reset(reset), .write_en(write_en), .write_adr(write_adr),
        .write_data(write_data), .write_byte_en(write_byte_en), .read_en(read_en),
        .read_adr(read_adr), .read_data(rd_d), .ready(rdy_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get(input int inst, input int port);
        case (inst)
            0:       return rd_n[port*32 +: 32];
            1:       return rd_o[port*32 +: 32];
            default: return rd_d[port*32 +: 32];
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic set_wr(input int adr, input logic [31:0] d, input logic [3:0] be);
        write_en      = 1'b1;
        write_adr     = 7'(adr);
        write_data    = d;
        write_byte_en = be;
        pend_we = 1'b1;
        pend_wa = adr;
        pend_wd = d;
        pend_be = be;
    endtask

    // Drive a read and queue the expected value of every instance.
    task automatic set_rd(input int p, input int adr, input string tag);
        logic [31:0] old_w, new_w;
        logic        hit;
        exp_t        e;
        read_en[p] = 1'b1;
        read_adr[p*7 +: 7] = 7'(adr);
        old_w = (adr < 64) ? model[adr] : 32'h0;
        hit   = pend_we && (pend_wa == adr) && (adr < 64);
        new_w = hit ? merge(old_w, pend_wd, pend_be) : old_w;
        for (int i = 0; i < 3; i++) begin
            e.tag  = $sformatf("%s_i%0d_p%0d", tag, i, p);
            e.inst = i;
            e.port = p;
            e.exp  = (i == 0) ? new_w : (i == 1) ? old_w : (hit ? ~new_w : old_w);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_we && pend_wa < 64)
            model[pend_wa] = merge(model[pend_wa], pend_wd, pend_be);
        pend_we  = 1'b0;
        write_en = 1'b0;
        read_en  = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, get(e.inst, e.port), e.exp);
        end
    endtask

    task automatic chk_ready(input string tag, input logic e);
        check({tag, "_n"}, {31'b0, rdy_n}, {31'b0, e});
        check({tag, "_o"}, {31'b0, rdy_o}, {31'b0, e});
        check({tag, "_d"}, {31'b0, rdy_d}, {31'b0, e});
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++)
            for (int p = 0; p < 4; p++)
                check($sformatf("%s_i%0d_p%0d", tag, i, p), get(i, p), 32'h0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 64; a += 4) begin
            for (int p = 0; p < 4; p++)
                set_rd(p, a + p, tag);
            step();
        end
    endtask

    initial begin
        int          adrs [4];
        logic [31:0] e;

        step();
        step();
        chk_ready("rst_ready", 1'b0);
        chk_zero("rst_rdata");

        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_ready($sformatf("clr_ready_c%0d", i), 1'b0);
            step();
        end
        chk_ready("clr_done", 1'b1);
        for (int a = 0; a < 64; a++) model[a] = 32'h0;

        set_rd(0, 0, "t1");
        set_rd(1, 17, "t1");
        set_rd(2, 33, "t1");
        set_rd(3, 63, "t1");
        step();

        set_wr(12, 32'h245fa7d4, 4'hf);
        step();
        set_wr(17, 32'h07b8261b, 4'hf);
        step();
        set_rd(0, 12, "t2");
        set_rd(1, 17, "t2");
        set_rd(2, 17, "t2");
        set_rd(3, 17, "t2");
        step();
        check("t2_p0_const", get(0, 0), 32'h245fa7d4);
        check("t2_p3_const", get(0, 3), 32'h07b8261b);

        set_wr(12, 32'hdff64bb1, 4'b0101);
        step();
        set_rd(0, 12, "t3");
        step();
        check("t3_const", get(0, 0), 32'h24f6a7b1);

        set_wr(19, 32'h47b06ea2, 4'hf);
        step();
        set_wr(19, 32'h8373b38a, 4'hf);
        set_rd(0, 12, "t4_col");
        set_rd(1, 17, "t4_col");
        set_rd(2, 19, "t4_col");
        step();
        check("t4_new_const", get(0, 2), 32'h8373b38a);
        check("t4_old_const", get(1, 2), 32'h47b06ea2);
        check("t4_dc_const", get(2, 2), 32'h7c8c4c75);
        set_rd(2, 19, "t4_after");
        step();
        set_wr(19, 32'h00000000, 4'b0011);
        set_rd(3, 19, "t4_part");
        set_rd(0, 19, "t4_part");
        step();
        set_wr(40, 32'hcafef00d, 4'b0000);
        step();
        set_rd(1, 40, "t4_nobe");
        step();

        adrs = '{12, 17, 19, 63};
        for (int p = 0; p < 4; p++)
            set_rd(p, adrs[p], "t6_rd");
        step();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 3; i++)
                for (int p = 0; p < 4; p++) begin
                    e = model[adrs[p]];
                    check($sformatf("t6_hold_c%0d_i%0d_p%0d", c, i, p), get(i, p), e);
                end
            step();
        end
        set_wr(64, 32'hffffffff, 4'hf);
        step();
        read_all("t6_oor");

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        reset = 1'b1;
        step();
        chk_ready("t5_rst_ready", 1'b0);
        chk_zero("t5_rst_rdata");
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_ready($sformatf("t5_ready_c%0d", i), 1'b0);
            if (i == 10 || i == 40) begin
                read_en       = 4'hf;
                read_adr      = {7'd12, 7'd17, 7'd19, 7'd5};
                write_en      = 1'b1;
                write_adr     = 7'd5;
                write_data    = 32'hffffffff;
                write_byte_en = 4'hf;
                step();
                chk_zero($sformatf("t5_ign_c%0d", i));
            end else begin
                step();
            end
        end
        chk_ready("t5_done", 1'b1);
        for (int a = 0; a < 64; a++) model[a] = 32'h0;
        read_all("t5_zero");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
